// File: rtl/epochtv1_vram_arb_if.sv
// Bus bundle between the TV-1 VRAM arbiter, its two requesters and the VRAM macro.
// slave = arbiter view; master = requesters plus memory side.
interface epochtv1_vram_arb_if;
  logic        VID_REQ;
  logic [10:0] VID_A;
  logic        VID_ACK;
  logic [15:0] VID_D;
  logic        VID_DV;
  logic        CPU_REQ;
  logic        CPU_WE;
  logic [11:0] CPU_A;
  logic [7:0]  CPU_DI;
  logic [7:0]  CPU_DO;
  logic        CPU_ACK;
  logic [10:0] MEM_A;
  logic        MEM_RD;
  logic [1:0]  MEM_WE;
  logic [15:0] MEM_WD;
  logic [15:0] MEM_RDATA;

  modport slave (
    input  VID_REQ, VID_A, CPU_REQ, CPU_WE, CPU_A, CPU_DI, MEM_RDATA,
    output VID_ACK, VID_D, VID_DV, CPU_DO, CPU_ACK, MEM_A, MEM_RD, MEM_WE, MEM_WD
  );

  modport master (
    output VID_REQ, VID_A, CPU_REQ, CPU_WE, CPU_A, CPU_DI, MEM_RDATA,
    input  VID_ACK, VID_D, VID_DV, CPU_DO, CPU_ACK, MEM_A, MEM_RD, MEM_WE, MEM_WD
  );
endinterface

// File: rtl/epochtv1_vram_arb.sv
// Single-port VRAM arbiter: video fetch has priority, CPU byte path is protected from
// starvation by a saturating lost-slot counter.
module epochtv1_vram_arb #(
  parameter int unsigned STARVE_MAX = 4
) (
  input logic                CLK,
  input logic                RST,
  input logic                CE,
  epochtv1_vram_arb_if.slave bus
);

  typedef enum logic [0:0] {CIdle, CBusy} cpu_st_e;

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  cpu_st_e     c_state_q, c_state_d;
  logic [3:0]  starve_q, starve_d;
  logic        cpu_ack_q, cpu_rd_q, cpu_lane_q, vid_dv_q;
  logic [7:0]  cpu_do_q;
  logic        slot, cpu_elig, gnt_cpu, gnt_vid;
  logic [7:0]  lane_byte;

  always_comb begin
    slot     = CE & ~RST;
    cpu_elig = bus.CPU_REQ & (c_state_q == CIdle) & ~cpu_ack_q;
    gnt_cpu  = 1'b0;
    gnt_vid  = 1'b0;
    if (slot) begin
      if (cpu_elig && (starve_q == StarveMax)) gnt_cpu = 1'b1;
      else if (bus.VID_REQ)                    gnt_vid = 1'b1;
      else if (cpu_elig)                       gnt_cpu = 1'b1;
    end
  end

  always_comb begin
    c_state_d = c_state_q;
    starve_d  = starve_q;
    if (slot) begin
      unique case (c_state_q)
        CIdle: if (gnt_cpu) c_state_d = CBusy;
        CBusy: c_state_d = CIdle;
      endcase
      if (gnt_cpu) begin
        starve_d = 4'd0;
      end else if (cpu_elig && gnt_vid && (starve_q < StarveMax)) begin
        starve_d = starve_q + 4'd1;
      end
    end
  end

  always_comb begin
    bus.VID_ACK = gnt_vid;
    bus.MEM_A   = 11'd0;
    bus.MEM_RD  = 1'b0;
    bus.MEM_WE  = 2'b00;
    bus.MEM_WD  = 16'd0;
    if (gnt_vid) begin
      bus.MEM_A  = bus.VID_A;
      bus.MEM_RD = 1'b1;
    end else if (gnt_cpu) begin
      bus.MEM_A = bus.CPU_A[11:1];
      if (bus.CPU_WE) begin
        bus.MEM_WD = {bus.CPU_DI, bus.CPU_DI};
        bus.MEM_WE = bus.CPU_A[0] ? 2'b10 : 2'b01;
      end else begin
        bus.MEM_RD = 1'b1;
      end
    end
  end

  // Read data arrives in the ACK/DV slot, so it is passed through then and latched for holding.
  assign lane_byte = cpu_lane_q ? bus.MEM_RDATA[15:8] : bus.MEM_RDATA[7:0];

  always_ff @(posedge CLK) begin
    if (RST) begin
      c_state_q  <= CIdle;
      starve_q   <= 4'd0;
      cpu_ack_q  <= 1'b0;
      cpu_rd_q   <= 1'b0;
      cpu_lane_q <= 1'b0;
      vid_dv_q   <= 1'b0;
      cpu_do_q   <= 8'd0;
    end else if (CE) begin
      c_state_q <= c_state_d;
      starve_q  <= starve_d;
      cpu_ack_q <= gnt_cpu;
      vid_dv_q  <= gnt_vid;
      if (gnt_cpu) begin
        cpu_rd_q   <= ~bus.CPU_WE;
        cpu_lane_q <= bus.CPU_A[0];
      end
      if (cpu_ack_q && cpu_rd_q) cpu_do_q <= lane_byte;
    end
  end

  // Outputs read as 0 while RST is held so a transfer cut by reset never shows completion.
  assign bus.CPU_ACK = cpu_ack_q & ~RST;
  assign bus.VID_DV  = vid_dv_q & ~RST;
  assign bus.VID_D   = (vid_dv_q && !RST) ? bus.MEM_RDATA : 16'd0;
  assign bus.CPU_DO  = RST ? 8'd0 : ((cpu_ack_q && cpu_rd_q) ? lane_byte : cpu_do_q);

endmodule
